// File: rtl/utap_pkg.sv
// Shared UTAP framing definitions, used by utap_host and by the debug unit's receiver.
// Optional build macro: UTAP_HOST_PARITY_EN (adds an even-parity bit after data bit 7).
package utap_pkg;

    localparam int   UTAP_DATA_BITS = 8;
    localparam logic UTAP_IDLE_LVL  = 1'b1;
    localparam logic UTAP_START_LVL = 1'b0;

    typedef enum logic [3:0] {
        IDLE,
        TX_START,
        TX_DATA,
        TX_PAR,
        TX_STOP,
        RX_WAIT,
        RX_START,
        RX_DATA,
        RX_PAR,
        RX_STOP
    } utap_state_t;

    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic even_parity(input logic [UTAP_DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/utap_bit_timer.sv
// Bit-period timer for the UTAP host: reloads on load_i or at end of bit, flags end-of-bit
// and mid-bit. bit_tick_o lands CLKS_PER_BIT cycles after a load, mid_tick_o floor(CLKS_PER_BIT/2).
module utap_bit_timer
    import utap_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    output logic bit_tick_o,
    output logic mid_tick_o
);

    localparam int            TW     = $clog2(CLKS_PER_BIT + 1);
    localparam logic [TW-1:0] RELOAD = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] MID    = TW'(CLKS_PER_BIT - CLKS_PER_BIT / 2);

    logic [TW-1:0] cnt_q, cnt_d;

    // NOTE: next-state logic is combinational with a default first, so no latch can be inferred.
    always_comb begin
        cnt_d = cnt_q - TW'(1);
        if (load_i || cnt_q == '0) begin
            cnt_d = RELOAD;
        end
    end

    // NOTE: sequential state is updated with <= only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= RELOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_tick_o = (cnt_q == '0);
    assign mid_tick_o = (cnt_q == MID);

endmodule

// File: rtl/utap_host.sv
// Host-side UTAP driver: serializes command bytes onto utap_rx and deserializes replies from utap_out.
// Optional build macro: UTAP_HOST_PARITY_EN (11-bit frames with even parity in both directions).
module utap_host
    import utap_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int RSP_TIMEOUT  = 256
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_sel,
    input  logic [7:0] cmd_data,
    input  logic       cmd_rsp,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_err,
    output logic       busy,
    output logic [2:0] utap_sel,
    output logic       utap_rx,
    input  logic       utap_out
);

    localparam int                MAX_CNT = (CLKS_PER_BIT > RSP_TIMEOUT) ? CLKS_PER_BIT : RSP_TIMEOUT;
    localparam int                CNT_W   = $clog2(MAX_CNT + 1);
    localparam logic [CNT_W-1:0]  TO_LAST = CNT_W'(RSP_TIMEOUT - 1);
    localparam logic [3:0]        LAST_BIT = 4'(UTAP_DATA_BITS - 1);

    utap_state_t               state_q;
    logic                      utap_rx_q, cmd_ready_q, rsp_valid_q, rsp_err_q, rsp_req_q;
    logic [2:0]                utap_sel_q;
    logic [UTAP_DATA_BITS-1:0] rsp_data_q, tx_shift_q, rx_shift_q;
    logic [3:0]                bit_cnt_q;
    logic [CNT_W-1:0]          to_cnt_q;
    logic                      sync1_q, sync2_q;
`ifdef UTAP_HOST_PARITY_EN
    logic                      tx_par_q, par_err_q;
`endif

    logic accept, timer_load, bit_tick, mid_tick;

    assign accept = cmd_valid && cmd_ready_q;

    // The timer auto-reloads on bit_tick, so only transitions off the bit grid need an explicit restart.
    assign timer_load = accept
                     || (state_q == RX_WAIT  && sync2_q == UTAP_START_LVL)
                     || (state_q == RX_START && mid_tick);

    utap_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (timer_load),
        .bit_tick_o (bit_tick),
        .mid_tick_o (mid_tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= UTAP_IDLE_LVL;
            sync2_q <= UTAP_IDLE_LVL;
        end else begin
            sync1_q <= utap_out;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            utap_rx_q   <= UTAP_IDLE_LVL;
            utap_sel_q  <= '0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            rsp_req_q   <= 1'b0;
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            bit_cnt_q   <= '0;
            to_cnt_q    <= '0;
`ifdef UTAP_HOST_PARITY_EN
            tx_par_q    <= 1'b0;
            par_err_q   <= 1'b0;
`endif
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: if (accept) begin
                    state_q     <= TX_START;
                    cmd_ready_q <= 1'b0;
                    utap_sel_q  <= cmd_sel;
                    tx_shift_q  <= cmd_data;
                    rsp_req_q   <= cmd_rsp;
                    utap_rx_q   <= UTAP_START_LVL;
                    bit_cnt_q   <= '0;
`ifdef UTAP_HOST_PARITY_EN
                    tx_par_q    <= even_parity(cmd_data);
`endif
                end
                TX_START: if (bit_tick) begin
                    state_q    <= TX_DATA;
                    utap_rx_q  <= tx_shift_q[0];
                    tx_shift_q <= tx_shift_q >> 1;
                end
                TX_DATA: if (bit_tick) begin
                    if (bit_cnt_q == LAST_BIT) begin
`ifdef UTAP_HOST_PARITY_EN
                        state_q   <= TX_PAR;
                        utap_rx_q <= tx_par_q;
`else
                        state_q   <= TX_STOP;
                        utap_rx_q <= UTAP_IDLE_LVL;
`endif
                    end else begin
                        bit_cnt_q  <= bit_cnt_q + 4'd1;
                        utap_rx_q  <= tx_shift_q[0];
                        tx_shift_q <= tx_shift_q >> 1;
                    end
                end
`ifdef UTAP_HOST_PARITY_EN
                TX_PAR: if (bit_tick) begin
                    state_q   <= TX_STOP;
                    utap_rx_q <= UTAP_IDLE_LVL;
                end
`endif
                TX_STOP: if (bit_tick) begin
                    to_cnt_q  <= '0;
                    bit_cnt_q <= '0;
                    if (rsp_req_q) begin
                        state_q <= RX_WAIT;
                    end else begin
                        state_q     <= IDLE;
                        cmd_ready_q <= 1'b1;
                    end
                end
                RX_WAIT: begin
                    if (to_cnt_q >= TO_LAST) begin
                        state_q     <= IDLE;
                        cmd_ready_q <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_data_q  <= '0;
                    end else begin
                        to_cnt_q <= to_cnt_q + CNT_W'(1);
                        if (sync2_q == UTAP_START_LVL) state_q <= RX_START;
                    end
                end
                // A glitch returns to RX_WAIT without clearing the timeout count.
                RX_START: begin
                    if (to_cnt_q != '1) to_cnt_q <= to_cnt_q + CNT_W'(1);
                    if (mid_tick) state_q <= (sync2_q == UTAP_START_LVL) ? RX_DATA : RX_WAIT;
                end
                RX_DATA: if (bit_tick) begin
                    rx_shift_q <= {sync2_q, rx_shift_q[UTAP_DATA_BITS-1:1]};
                    if (bit_cnt_q == LAST_BIT) begin
`ifdef UTAP_HOST_PARITY_EN
                        state_q <= RX_PAR;
`else
                        state_q <= RX_STOP;
`endif
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                    end
                end
`ifdef UTAP_HOST_PARITY_EN
                RX_PAR: if (bit_tick) begin
                    par_err_q <= (sync2_q != even_parity(rx_shift_q));
                    state_q   <= RX_STOP;
                end
`endif
                RX_STOP: if (bit_tick) begin
                    state_q     <= IDLE;
                    cmd_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b1;
                    rsp_data_q  <= rx_shift_q;
`ifdef UTAP_HOST_PARITY_EN
                    rsp_err_q   <= (sync2_q != UTAP_IDLE_LVL) | par_err_q;
`else
                    rsp_err_q   <= (sync2_q != UTAP_IDLE_LVL);
`endif
                end
                default: begin
                    state_q     <= IDLE;
                    cmd_ready_q <= 1'b1;
                    utap_rx_q   <= UTAP_IDLE_LVL;
                end
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign busy      = ~cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign utap_sel  = utap_sel_q;
    assign utap_rx   = utap_rx_q;

endmodule

// File: tb/tb_utap_host.sv
// Scoreboard bench for utap_host: directed commands, a reply model on utap_out, and a response monitor.
// Build with UTAP_HOST_PARITY_EN defined to exercise 11-bit parity frames.
`timescale 1ns/1ps
module tb_utap_host;

    localparam int CPB = 4;
    localparam int TO  = 256;
`ifdef UTAP_HOST_PARITY_EN
    localparam int FRAME_BITS = 11;
    localparam logic [10:0] LINE_A5 = 11'b101_0100_1010;
    localparam logic [10:0] LINE_96 = 11'b101_0010_1100;
`else
    localparam int FRAME_BITS = 10;
    localparam logic [10:0] LINE_A5 = 11'b011_0100_1010;
    localparam logic [10:0] LINE_96 = 11'b011_0010_1100;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [2:0] cmd_sel = '0;
    logic [7:0] cmd_data = '0;
    logic       cmd_rsp = 1'b0;
    logic       utap_out = 1'b1;
    logic       cmd_ready, rsp_valid, rsp_err, busy, utap_rx;
    logic [7:0] rsp_data;
    logic [2:0] utap_sel;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        logic [7:0] data;
        logic       err;
        int         at;     // expected cycle of rsp_valid, -1 = any
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    utap_host #(.CLKS_PER_BIT(CPB), .RSP_TIMEOUT(TO)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_sel   (cmd_sel),
        .cmd_data  (cmd_data),
        .cmd_rsp   (cmd_rsp),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .utap_sel  (utap_sel),
        .utap_rx   (utap_rx),
        .utap_out  (utap_out)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rsp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected_valid", 32'(rsp_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("rsp_data", 32'(rsp_data), 32'(e.data));
                check("rsp_err", 32'(rsp_err), 32'(e.err));
                if (e.at >= 0) check("rsp_cycle", cyc, e.at);
            end
        end
    end

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic send_cmd(input logic [2:0] sel, input logic [7:0] data, input logic rsp, output int acc);
        for (int i = 0; i < 2000 && cmd_ready !== 1'b1; i++) @(negedge clk);
        check("cmd_ready_wait", 32'(cmd_ready), 32'd1);
        cmd_sel   = sel;
        cmd_data  = data;
        cmd_rsp   = rsp;
        cmd_valid = 1'b1;
        @(negedge clk);
        acc       = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic check_frame(input logic [10:0] line, input int acc);
        for (int i = 0; i < FRAME_BITS; i++) begin
            wait_until(acc + i * CPB + CPB / 2);
            check($sformatf("tx_bit%0d", i), 32'(utap_rx), 32'(line[i]));
        end
    endtask

    task automatic send_reply(input logic [7:0] d, input logic stop, input logic par_flip);
        utap_out = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            utap_out = d[i];
            repeat (CPB) @(negedge clk);
        end
`ifdef UTAP_HOST_PARITY_EN
        utap_out = (^d) ^ par_flip;
        repeat (CPB) @(negedge clk);
`endif
        utap_out = stop;
        repeat (CPB) @(negedge clk);
        utap_out = 1'b1;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
        check("rsp_drain", 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int a;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_utap_rx", 32'(utap_rx), 32'd1);
        check("rst_utap_sel", 32'(utap_sel), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // TX only, A5 on unit 2
        send_cmd(3'd2, 8'hA5, 1'b0, a);
        check("sel_on_accept", 32'(utap_sel), 32'd2);
        check("busy_on_accept", 32'(busy), 32'd1);
        check_frame(LINE_A5, a);
        wait_until(a + FRAME_BITS * CPB - 1);
        check("ready_before_end", 32'(cmd_ready), 32'd0);
        wait_until(a + FRAME_BITS * CPB);
        check("ready_at_end", 32'(cmd_ready), 32'd1);
        check("sel_held", 32'(utap_sel), 32'd2);

        // cmd_valid offered while busy must be ignored
        send_cmd(3'd3, 8'h96, 1'b0, a);
        fork
            check_frame(LINE_96, a);
            begin
                wait_until(a + 3);
                cmd_sel   = 3'd5;
                cmd_data  = 8'hFF;
                cmd_rsp   = 1'b1;
                cmd_valid = 1'b1;
                wait_until(a + 30);
                cmd_valid = 1'b0;
            end
        join
        wait_until(a + FRAME_BITS * CPB);
        check("busy_ready_at_end", 32'(cmd_ready), 32'd1);
        check("busy_sel_kept", 32'(utap_sel), 32'd3);

        // Command with a good reply
        send_cmd(3'd1, 8'h3C, 1'b1, a);
        wait_until(a + FRAME_BITS * CPB + 10);
        exp_q.push_back('{data: 8'hC3, err: 1'b0, at: -1});
        send_reply(8'hC3, 1'b1, 1'b0);
        drain(200);
        repeat (5) @(negedge clk);
        check("rsp_data_hold", 32'(rsp_data), 32'hC3);
        check("rsp_valid_pulse", 32'(rsp_valid), 32'd0);

        // Timeout with utap_out idle
        send_cmd(3'd4, 8'h5A, 1'b1, a);
        exp_q.push_back('{data: 8'h00, err: 1'b1, at: a + FRAME_BITS * CPB + TO});
        drain(FRAME_BITS * CPB + TO + 50);

        // Reply with a bad stop bit
        send_cmd(3'd0, 8'h11, 1'b1, a);
        wait_until(a + FRAME_BITS * CPB + 10);
        exp_q.push_back('{data: 8'h6B, err: 1'b1, at: -1});
        send_reply(8'h6B, 1'b0, 1'b0);
        drain(200);

        // One-cycle glitch in RX_WAIT, then a real reply
        send_cmd(3'd6, 8'h22, 1'b1, a);
        wait_until(a + FRAME_BITS * CPB + 5);
        utap_out = 1'b0;
        @(negedge clk);
        utap_out = 1'b1;
        wait_until(a + FRAME_BITS * CPB + 20);
        exp_q.push_back('{data: 8'h9E, err: 1'b0, at: -1});
        send_reply(8'h9E, 1'b1, 1'b0);
        drain(200);

`ifdef UTAP_HOST_PARITY_EN
        // Parity frames: TX 01 carries parity 1; a reply with flipped parity is an error
        send_cmd(3'd7, 8'h01, 1'b0, a);
        check_frame(11'b110_0000_0010, a);
        send_cmd(3'd7, 8'h44, 1'b1, a);
        wait_until(a + FRAME_BITS * CPB + 10);
        exp_q.push_back('{data: 8'h44, err: 1'b1, at: -1});
        send_reply(8'h44, 1'b1, 1'b1);
        drain(200);
`endif

        // Reset mid-TX_DATA aborts the frame with no response
        send_cmd(3'd5, 8'h55, 1'b1, a);
        wait_until(a + 2 * CPB + 1);
        check("pre_abort_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("abort_utap_rx", 32'(utap_rx), 32'd1);
        check("abort_cmd_ready", 32'(cmd_ready), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_sel", 32'(utap_sel), 32'd0);
        reset = 1'b0;
        repeat (FRAME_BITS * CPB + TO + 20) @(negedge clk);
        check("abort_no_rsp", 32'(exp_q.size()), 32'd0);
        check("abort_idle_ready", 32'(cmd_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
